// File: rtl/fmt_ram_access_arbiter.sv
// rtl/fmt_ram_access_arbiter.sv - fmt RAM port arbiter between config path and lookup engine
// Lookup has priority; a starvation counter forces a config grant after CFG_MAX_WAIT denials.
module fmt_ram_access_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 131,
  parameter int RD_LAT       = 1,
  parameter int CFG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_req,
  input  logic              i_cfg_wr,
  input  logic [ADDR_W-1:0] iv_cfg_addr,
  input  logic [DATA_W-1:0] iv_cfg_wdata,
  output logic              o_cfg_ack,
  output logic [DATA_W-1:0] ov_cfg_rdata,
  output logic              o_cfg_rdata_valid,
  input  logic              i_lkp_req,
  input  logic [ADDR_W-1:0] iv_lkp_addr,
  output logic              o_lkp_ack,
  output logic [DATA_W-1:0] ov_lkp_rdata,
  output logic              o_lkp_rdata_valid,
  output logic [ADDR_W-1:0] ov_ram_addr,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  output logic [DATA_W-1:0] ov_ram_wdata,
  input  logic [DATA_W-1:0] iv_ram_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(CFG_MAX_WAIT);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        grant_cfg, grant_lkp;
  logic        rd_nxt;

  // tag_own = 1 marks a config read; stage 0 lines up with the o_ram_rd cycle
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_own;

  always_comb begin
    grant_cfg = 1'b0;
    grant_lkp = 1'b0;
    state_nxt = NORMAL;
    cnt_nxt   = cnt;
    case (state)
      FORCE: begin
        if (i_cfg_req)      grant_cfg = 1'b1;
        else if (i_lkp_req) grant_lkp = 1'b1;
      end
      default: begin
        if (i_lkp_req)      grant_lkp = 1'b1;
        else if (i_cfg_req) grant_cfg = 1'b1;
      end
    endcase
    if (!i_cfg_req || grant_cfg)
      cnt_nxt = 4'd0;
    else if (cnt < MAX_CNT)
      cnt_nxt = cnt + 4'd1;
    if (state == NORMAL && i_cfg_req && !grant_cfg && cnt_nxt == MAX_CNT)
      state_nxt = FORCE;
    rd_nxt = grant_lkp || (grant_cfg && !i_cfg_wr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= NORMAL;
      cnt               <= 4'd0;
      o_cfg_ack         <= 1'b0;
      o_lkp_ack         <= 1'b0;
      o_ram_wr          <= 1'b0;
      o_ram_rd          <= 1'b0;
      ov_ram_addr       <= '0;
      ov_ram_wdata      <= '0;
      tag_vld           <= '0;
      tag_own           <= '0;
      o_cfg_rdata_valid <= 1'b0;
      o_lkp_rdata_valid <= 1'b0;
      ov_cfg_rdata      <= '0;
      ov_lkp_rdata      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      o_cfg_ack    <= grant_cfg;
      o_lkp_ack    <= grant_lkp;
      o_ram_wr     <= grant_cfg && i_cfg_wr;
      o_ram_rd     <= rd_nxt;
      ov_ram_addr  <= grant_cfg ? iv_cfg_addr : (grant_lkp ? iv_lkp_addr : '0);
      ov_ram_wdata <= grant_cfg ? iv_cfg_wdata : '0;

      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      tag_vld[0] <= rd_nxt;
      tag_own[0] <= grant_cfg;

      // RAM q is sampled on the edge closing cycle rd+RD_LAT-1
      o_cfg_rdata_valid <= tag_vld[RD_LAT-1] && tag_own[RD_LAT-1];
      o_lkp_rdata_valid <= tag_vld[RD_LAT-1] && !tag_own[RD_LAT-1];
      if (tag_vld[RD_LAT-1] && tag_own[RD_LAT-1])
        ov_cfg_rdata <= iv_ram_rdata;
      if (tag_vld[RD_LAT-1] && !tag_own[RD_LAT-1])
        ov_lkp_rdata <= iv_ram_rdata;
    end
  end

endmodule

// File: tb/tb_fmt_ram_access_arbiter.sv
// tb/tb_fmt_ram_access_arbiter.sv - self-checking bench for fmt_ram_access_arbiter
// Two DUTs (RD_LAT 1 and 3) share stimulus; a denial-count model predicts grants and returns.
module tb_fmt_ram_access_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         cfg_req, cfg_wr, lkp_req;
  logic [4:0]   cfg_addr, lkp_addr;
  logic [130:0] cfg_wdata;

  logic         cfg_ack0, cfg_rv0, lkp_ack0, lkp_rv0, ram_wr0, ram_rd0;
  logic [130:0] cfg_rdata0, lkp_rdata0, ram_wdata0, ram_rdata0;
  logic [4:0]   ram_addr0;
  logic         cfg_ack1, cfg_rv1, lkp_ack1, lkp_rv1, ram_wr1, ram_rd1;
  logic [130:0] cfg_rdata1, lkp_rdata1, ram_wdata1, ram_rdata1;
  logic [4:0]   ram_addr1;

  fmt_ram_access_arbiter #(.RD_LAT(LAT0), .CFG_MAX_WAIT(MAX_WAIT)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_req(cfg_req), .i_cfg_wr(cfg_wr), .iv_cfg_addr(cfg_addr), .iv_cfg_wdata(cfg_wdata),
    .o_cfg_ack(cfg_ack0), .ov_cfg_rdata(cfg_rdata0), .o_cfg_rdata_valid(cfg_rv0),
    .i_lkp_req(lkp_req), .iv_lkp_addr(lkp_addr),
    .o_lkp_ack(lkp_ack0), .ov_lkp_rdata(lkp_rdata0), .o_lkp_rdata_valid(lkp_rv0),
    .ov_ram_addr(ram_addr0), .o_ram_wr(ram_wr0), .o_ram_rd(ram_rd0),
    .ov_ram_wdata(ram_wdata0), .iv_ram_rdata(ram_rdata0));

  fmt_ram_access_arbiter #(.RD_LAT(LAT1), .CFG_MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_req(cfg_req), .i_cfg_wr(cfg_wr), .iv_cfg_addr(cfg_addr), .iv_cfg_wdata(cfg_wdata),
    .o_cfg_ack(cfg_ack1), .ov_cfg_rdata(cfg_rdata1), .o_cfg_rdata_valid(cfg_rv1),
    .i_lkp_req(lkp_req), .iv_lkp_addr(lkp_addr),
    .o_lkp_ack(lkp_ack1), .ov_lkp_rdata(lkp_rdata1), .o_lkp_rdata_valid(lkp_rv1),
    .ov_ram_addr(ram_addr1), .o_ram_wr(ram_wr1), .o_ram_rd(ram_rd1),
    .ov_ram_wdata(ram_wdata1), .iv_ram_rdata(ram_rdata1));

  // RAM models: write-first, q presented in cycle rd+RD_LAT-1
  logic [130:0] mem0 [32];
  logic [130:0] mem1 [32];
  logic [130:0] q1_p0, q1_p1;
  assign ram_rdata0 = mem0[ram_addr0];
  assign ram_rdata1 = q1_p1;
  always @(posedge clk) begin
    if (ram_wr0) mem0[ram_addr0] <= ram_wdata0;
    if (ram_wr1) mem1[ram_addr1] <= ram_wdata1;
    q1_p0 <= mem1[ram_addr1];
    q1_p1 <= q1_p0;
  end

  // reference model state
  logic [130:0] ref_mem [32];
  int           denials;
  int unsigned  cyc;
  bit           sv_v [2][8];
  bit           sv_c [2][8];
  logic [130:0] sv_d [2][8];
  logic [130:0] hold_c [2];
  logic [130:0] hold_l [2];
  bit           e_cv [2];
  bit           e_lv [2];
  bit           e_gc, e_gl, e_wr, e_rd;
  logic [4:0]   e_addr;
  logic [130:0] e_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input string pre, input int k,
                            input logic cack, input logic lack, input logic wr, input logic rd,
                            input logic [4:0] addr, input logic [130:0] wdata,
                            input logic cv, input logic lv,
                            input logic [130:0] crd, input logic [130:0] lrd);
    check({pre, "cfg_ack"},   131'(cack),  131'(e_gc));
    check({pre, "lkp_ack"},   131'(lack),  131'(e_gl));
    check({pre, "ram_wr"},    131'(wr),    131'(e_wr));
    check({pre, "ram_rd"},    131'(rd),    131'(e_rd));
    check({pre, "ram_addr"},  131'(addr),  131'(e_addr));
    check({pre, "ram_wdata"}, wdata,       e_wdata);
    check({pre, "cfg_rv"},    131'(cv),    131'(e_cv[k]));
    check({pre, "lkp_rv"},    131'(lv),    131'(e_lv[k]));
    check({pre, "cfg_rdata"}, crd,         hold_c[k]);
    check({pre, "lkp_rdata"}, lrd,         hold_l[k]);
  endtask

  task automatic check_both();
    check_outs("L1_", 0, cfg_ack0, lkp_ack0, ram_wr0, ram_rd0, ram_addr0, ram_wdata0,
               cfg_rv0, lkp_rv0, cfg_rdata0, lkp_rdata0);
    check_outs("L3_", 1, cfg_ack1, lkp_ack1, ram_wr1, ram_rd1, ram_addr1, ram_wdata1,
               cfg_rv1, lkp_rv1, cfg_rdata1, lkp_rdata1);
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic step();
    logic [130:0] rdv;
    int slot;
    int lat;
    e_gc    = cfg_req && (!lkp_req || denials == MAX_WAIT);
    e_gl    = lkp_req && !e_gc;
    e_wr    = e_gc && cfg_wr;
    e_rd    = e_gl || (e_gc && !cfg_wr);
    e_addr  = e_gc ? cfg_addr : (e_gl ? lkp_addr : 5'd0);
    e_wdata = e_gc ? cfg_wdata : '0;
    if (!cfg_req || e_gc) denials = 0;
    else if (denials < MAX_WAIT) denials++;
    rdv = ref_mem[e_addr];
    if (e_wr) ref_mem[e_addr] = cfg_wdata;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      slot = int'(cyc % 8);
      e_cv[k] = sv_v[k][slot] && sv_c[k][slot];
      e_lv[k] = sv_v[k][slot] && !sv_c[k][slot];
      if (e_cv[k]) hold_c[k] = sv_d[k][slot];
      if (e_lv[k]) hold_l[k] = sv_d[k][slot];
      sv_v[k][slot] = 1'b0;
      if (e_rd) begin
        lat = (k == 0) ? LAT0 : LAT1;
        slot = int'((cyc + lat) % 8);
        sv_v[k][slot] = 1'b1;
        sv_c[k][slot] = e_gc;
        sv_d[k][slot] = rdv;
      end
    end
    check_both();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_req = 1'b0;
    lkp_req = 1'b0;
    e_gc = 0; e_gl = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_wdata = '0;
    denials = 0;
    for (int k = 0; k < 2; k++) begin
      e_cv[k] = 0; e_lv[k] = 0; hold_c[k] = '0; hold_l[k] = '0;
      for (int s = 0; s < 8; s++) sv_v[k][s] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_both();
    rst_n = 1'b1;
  endtask

  // Hold lookup, raise config, count lookup grants seen before the config ack.
  task automatic starve_run(input string tag);
    int n_lkp;
    bit seen;
    n_lkp = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (cfg_ack0) seen = 1'b1;
      else if (lkp_ack0) n_lkp++;
      lkp_addr = 5'($urandom_range(0, 7));
    end
    check(tag, 131'(n_lkp), 131'(MAX_WAIT));
    cfg_req = 1'b0;
  endtask

  logic [130:0] rv;

  initial begin
    cyc = 0;
    cfg_wr = 0; cfg_addr = '0; cfg_wdata = '0; lkp_addr = '0;
    for (int i = 0; i < 32; i++) begin
      rv = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mem0[i] = rv; mem1[i] = rv; ref_mem[i] = rv;
    end
    do_reset();
    do_reset();

    // lookup only, 5 then 9 back to back
    lkp_req = 1; lkp_addr = 5'd5; step();
    lkp_addr = 5'd9; step();
    lkp_req = 0;
    for (int i = 0; i < 4; i++) step();

    // config write 3 then read 3
    cfg_req = 1; cfg_wr = 1; cfg_addr = 5'd3; cfg_wdata = 131'h1ABC; step();
    cfg_wr = 0; step();
    cfg_req = 0;
    for (int i = 0; i < 4; i++) step();
    check("cfg_rdback", cfg_rdata1, 131'h1ABC);

    // starvation with a config read interleaved among lookup reads
    lkp_req = 1; lkp_addr = 5'd1;
    cfg_req = 1; cfg_wr = 0; cfg_addr = 5'd2;
    starve_run("starve_grants");
    for (int i = 0; i < 3; i++) step();

    // abandoned config request restarts the count
    cfg_req = 1; cfg_addr = 5'd4; step(); step();
    cfg_req = 0; step();
    cfg_req = 1;
    starve_run("restart_grants");
    lkp_req = 0;
    for (int i = 0; i < 4; i++) step();

    // reset with reads in flight
    lkp_req = 1; lkp_addr = 5'd6; step(); step();
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (cfg_req && !e_gc && $urandom_range(0, 15) == 0)
        cfg_req = 0;
      else if (!cfg_req || e_gc) begin
        cfg_req   = ($urandom_range(0, 2) == 0);
        cfg_wr    = 1'($urandom);
        cfg_addr  = 5'($urandom_range(0, 7));
        cfg_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (!lkp_req || e_gl) begin
        lkp_req  = ($urandom_range(0, 3) != 0) && (i % 500 < 400);
        lkp_addr = 5'($urandom_range(0, 7));
      end
      if (i == 1500) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
